// File: rtl/d_branch_resolver.sv
// D-stage branch resolver: eight-mode compare, 2-bit saturating-counter BHT
// read by F and trained by D, misprediction flag and branch statistics.
module d_branch_resolver #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int IDX_LSB   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      F_pc,
  output logic             F_pred_taken,
  input  logic             D_valid,
  input  logic             D_stall,
  input  logic [31:0]      D_pc,
  input  logic [WIDTH-1:0] D_Rdata1,
  input  logic [WIDTH-1:0] D_Rdata2,
  input  logic [2:0]       s_D_cmp,
  input  logic             D_pred_in,
  output logic             D_taken,
  output logic             D_mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'b000,
    CMP_BNE  = 3'b001,
    CMP_BLEZ = 3'b010,
    CMP_BGTZ = 3'b011,
    CMP_BLTZ = 3'b100,
    CMP_BGEZ = 3'b101,
    CMP_BLT  = 3'b110,
    CMP_BLTU = 3'b111
  } cmp_e;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  cmp_e             cmp_mode;
  logic             cond;
  logic             a_neg;
  logic             a_zero;
  logic             ev;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] d_idx;
  ctr_e             bht_q [BHT_DEPTH];
  ctr_e             entry_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;
  logic             unused_pc_bits;

  assign cmp_mode = cmp_e'(s_D_cmp);
  assign a_neg    = D_Rdata1[WIDTH-1];
  assign a_zero   = ~|D_Rdata1;

  always_comb begin
    // NOTE: default assigned before the case so no path leaves cond unassigned (no latch).
    cond = 1'b0;
    case (cmp_mode)
      CMP_BEQ:  cond = (D_Rdata1 == D_Rdata2);
      CMP_BNE:  cond = (D_Rdata1 != D_Rdata2);
      CMP_BLEZ: cond = a_neg | a_zero;
      CMP_BGTZ: cond = ~a_neg & ~a_zero;
      CMP_BLTZ: cond = a_neg;
      CMP_BGEZ: cond = ~a_neg;
      CMP_BLT:  cond = ($signed(D_Rdata1) < $signed(D_Rdata2));
      CMP_BLTU: cond = (D_Rdata1 < D_Rdata2);
      default:  cond = 1'b0;
    endcase
  end

  assign D_taken      = D_valid & cond;
  assign ev           = D_valid & ~D_stall;
  assign D_mispredict = ev & (D_taken ^ D_pred_in);

  // Only the index field of each PC matters; other bits alias by design.
  assign f_idx          = F_pc[IDX_LSB +: IDX_W];
  assign d_idx          = D_pc[IDX_LSB +: IDX_W];
  assign unused_pc_bits = ^{F_pc, D_pc};

  // Plain read of the stored counter: a same-cycle update is not bypassed.
  assign F_pred_taken = bht_q[f_idx][1];

  always_comb begin
    entry_d = bht_q[d_idx];
    if (D_taken) begin
      if (bht_q[d_idx] != CTR_STRONG_T) entry_d = ctr_e'(bht_q[d_idx] + 2'b01);
    end else begin
      if (bht_q[d_idx] != CTR_STRONG_NT) entry_d = ctr_e'(bht_q[d_idx] - 2'b01);
    end
  end

  assign branch_cnt_d  = branch_cnt_q + 32'd1;
  assign mispred_cnt_d = mispred_cnt_q + 32'd1;

  // NOTE: every BHT entry sits in the async reset so predictions are defined the instant reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_WEAK_NT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (ev) begin
      // NOTE: non-blocking assignments here; sequential state must all update together at the edge.
      bht_q[d_idx] <= entry_d;
      branch_cnt_q <= branch_cnt_d;
      if (D_mispredict) mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_d_branch_resolver.sv
// Self-checking bench for d_branch_resolver: a behavioural BHT/statistics model
// checked every negedge, plus directed vectors with hand-computed expectations.
module tb_d_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_pc;
  logic        F_pred_taken;
  logic        D_valid;
  logic        D_stall;
  logic [31:0] D_pc;
  logic [31:0] D_Rdata1;
  logic [31:0] D_Rdata2;
  logic [2:0]  s_D_cmp;
  logic        D_pred_in;
  logic        D_taken;
  logic        D_mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [1:0]  m_bht [16];
  logic [31:0] m_branch;
  logic [31:0] m_mis;
  logic        wrap_set = 1'b0;

  always #5 clk = ~clk;

  d_branch_resolver #(.WIDTH(32), .BHT_DEPTH(16), .IDX_LSB(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .F_pc         (F_pc),
    .F_pred_taken (F_pred_taken),
    .D_valid      (D_valid),
    .D_stall      (D_stall),
    .D_pc         (D_pc),
    .D_Rdata1     (D_Rdata1),
    .D_Rdata2     (D_Rdata2),
    .s_D_cmp      (s_D_cmp),
    .D_pred_in    (D_pred_in),
    .D_taken      (D_taken),
    .D_mispredict (D_mispredict),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Branch direction straight from the mode table, using integer arithmetic.
  function automatic logic ref_taken(input logic valid, input logic [2:0] mode,
                                     input logic [31:0] a, input logic [31:0] b);
    int  sa;
    int  sb;
    logic t;
    sa = $signed(a);
    sb = $signed(b);
    case (mode)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd2:    t = (sa <= 0);
      3'd3:    t = (sa > 0);
      3'd4:    t = (sa < 0);
      3'd5:    t = (sa >= 0);
      3'd6:    t = (sa < sb);
      default: t = (a < b);
    endcase
    return valid && t;
  endfunction

  function automatic logic ref_event();
    return D_valid && !D_stall;
  endfunction

  always @(posedge clk or negedge reset or posedge wrap_set) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) m_bht[i] <= 2'd1;
      m_branch <= '0;
      m_mis    <= '0;
    end else if (wrap_set) begin
      m_branch <= 32'hFFFF_FFFF;
    end else if (ref_event()) begin
      logic t;
      int   k;
      t = ref_taken(D_valid, s_D_cmp, D_Rdata1, D_Rdata2);
      k = int'(D_pc[5:2]);
      if (t)  m_bht[k] <= (m_bht[k] == 2'd3) ? 2'd3 : m_bht[k] + 2'd1;
      else    m_bht[k] <= (m_bht[k] == 2'd0) ? 2'd0 : m_bht[k] - 2'd1;
      m_branch <= m_branch + 32'd1;
      if (t != D_pred_in) m_mis <= m_mis + 32'd1;
    end
  end

  always @(negedge clk) begin
    logic t;
    t = ref_taken(D_valid, s_D_cmp, D_Rdata1, D_Rdata2);
    check("model_F_pred", 32'(F_pred_taken), 32'(m_bht[int'(F_pc[5:2])] >= 2'd2));
    check("model_D_taken", 32'(D_taken), 32'(t));
    check("model_D_mispredict", 32'(D_mispredict), 32'(ref_event() && (t != D_pred_in)));
    check("model_branch_cnt", branch_cnt, m_branch);
    check("model_mispred_cnt", mispred_cnt, m_mis);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic stall, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] mode, input logic pred);
    D_valid   = valid;
    D_stall   = stall;
    D_pc      = pc;
    D_Rdata1  = a;
    D_Rdata2  = b;
    s_D_cmp   = mode;
    D_pred_in = pred;
  endtask

  initial begin
    logic [7:0]  exp_neg_one;
    logic [7:0]  exp_zero;
    logic [31:0] mis_before;

    reset = 1'b0;
    F_pc  = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);

    // Reset sweep over every index.
    for (int i = 0; i < 16; i++) begin
      F_pc = 32'(i) << 2;
      #2;
      check("reset_F_pred", 32'(F_pred_taken), 32'd0);
    end
    check("reset_branch_cnt", branch_cnt, 32'd0);
    check("reset_mispred_cnt", mispred_cnt, 32'd0);
    next_cycle();
    reset = 1'b1;

    // Compare modes.
    exp_neg_one = 8'b0101_0110;
    exp_zero    = 8'b0010_0101;
    F_pc = 32'h0000_3024;
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 1'b0, 32'h0000_3024, 32'hFFFF_FFFF, 32'h0000_0001, 3'(m), 1'b0);
      #1;
      check($sformatf("mode%0d_neg_one", m), 32'(D_taken), 32'(exp_neg_one[m]));
      next_cycle();
    end
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 1'b0, 32'h0000_3024, 32'h0, 32'h0, 3'(m), 1'b0);
      #1;
      check($sformatf("mode%0d_zero", m), 32'(D_taken), 32'(exp_zero[m]));
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0000_3024, 32'h0, 32'h0, 3'd0, 1'b0);
    #1;
    check("invalid_taken", 32'(D_taken), 32'd0);

    // Training at 0x3008.
    F_pc = 32'h0000_3008;
    drive(1'b1, 1'b0, 32'h0000_3008, 32'd5, 32'd5, 3'd0, 1'b0);
    #1;
    check("train_pred0", 32'(F_pred_taken), 32'd0);
    next_cycle(); #1;
    check("train_pred1", 32'(F_pred_taken), 32'd1);
    next_cycle(); #1;
    check("train_pred2", 32'(F_pred_taken), 32'd1);
    drive(1'b1, 1'b0, 32'h0000_3008, 32'd5, 32'd5, 3'd0, 1'b1);
    next_cycle(); #1;
    check("train_pred3_sat", 32'(F_pred_taken), 32'd1);
    drive(1'b1, 1'b0, 32'h0000_3008, 32'd1, 32'd2, 3'd0, 1'b1);
    next_cycle(); #1;
    check("train_nt_weak_t", 32'(F_pred_taken), 32'd1);
    next_cycle(); #1;
    check("train_nt_weak_nt", 32'(F_pred_taken), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    #1;
    check("train_branch_cnt", branch_cnt, 32'd21);

    // Stall: one resolution when the stall drops.
    F_pc = 32'h0000_3010;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 32'h0000_3010, 32'd1, 32'd2, 3'd1, 1'b0);
      #1;
      check("stall_no_mispredict", 32'(D_mispredict), 32'd0);
      next_cycle();
    end
    check("stall_branch_cnt_hold", branch_cnt, 32'd21);
    check("stall_pred_hold", 32'(F_pred_taken), 32'd0);
    D_stall = 1'b0;
    #1;
    check("stall_release_mispredict", 32'(D_mispredict), 32'd1);
    next_cycle();
    D_valid = 1'b0;
    #1;
    check("stall_branch_cnt", branch_cnt, 32'd22);
    check("stall_pred_after", 32'(F_pred_taken), 32'd1);
    next_cycle(); #1;
    check("stall_branch_cnt_idle", branch_cnt, 32'd22);

    // Mispredict, collision and aliasing at index 0.
    F_pc = 32'h0000_3000;
    drive(1'b1, 1'b0, 32'h0000_3000, 32'd7, 32'd7, 3'd0, 1'b0);
    #1;
    check("collide_mispredict", 32'(D_mispredict), 32'd1);
    check("collide_old_pred", 32'(F_pred_taken), 32'd0);
    mis_before = m_mis;
    next_cycle();
    D_valid = 1'b0;
    F_pc = 32'h0000_3040;
    #1;
    check("alias_pred_taken", 32'(F_pred_taken), 32'd1);
    check("mispred_cnt_inc", mispred_cnt, mis_before + 32'd1);
    drive(1'b1, 1'b0, 32'h0000_3040, 32'd7, 32'd7, 3'd0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_3000, 32'd7, 32'd8, 3'd0, 1'b1);
    next_cycle(); #1;
    check("alias_strong_then_weak", 32'(F_pred_taken), 32'd1);
    next_cycle(); #1;
    check("alias_weak_nt", 32'(F_pred_taken), 32'd0);
    D_valid = 1'b0;

    // Statistics wrap.
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    wrap_set = 1'b1;
    #1;
    release dut.branch_cnt_q;
    wrap_set = 1'b0;
    #1;
    check("wrap_preset", branch_cnt, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0000_3024, 32'd1, 32'd1, 3'd0, 1'b1);
    next_cycle();
    D_valid = 1'b0;
    #1;
    check("wrap_to_zero", branch_cnt, 32'd0);

    // Mid-training asynchronous reset.
    F_pc = 32'h0000_3008;
    drive(1'b1, 1'b0, 32'h0000_3008, 32'd5, 32'd5, 3'd0, 1'b1);
    next_cycle(); #1;
    check("midreset_trained", 32'(F_pred_taken), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("midreset_branch_cnt", branch_cnt, 32'd0);
    check("midreset_mispred_cnt", mispred_cnt, 32'd0);
    check("midreset_pred", 32'(F_pred_taken), 32'd0);
    next_cycle(); #1;
    check("midreset_no_update", branch_cnt, 32'd0);
    reset = 1'b1;
    D_valid = 1'b0;
    next_cycle(); #1;
    check("postreset_pred", 32'(F_pred_taken), 32'd0);
    check("postreset_branch_cnt", branch_cnt, 32'd0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
